// File: rtl/lsu_pkg.sv
// Shared types for the load/store queue: FSM state encoding, opcode store-bit
// position and the default queue-entry layout.
package lsu_pkg;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_REQUEST   = 2'd1,
      ST_WAIT_RESP = 2'd2,
      ST_WRITEBACK = 2'd3
   } lsu_state_e;

   localparam int unsigned LSU_STORE_BIT = 3;

   localparam int unsigned LSU_DATA_W = 16;
   localparam int unsigned LSU_REG_W  = 4;

   typedef struct packed {
      logic                  store;
      logic [LSU_DATA_W-1:0] addr;
      logic [LSU_DATA_W-1:0] wdata;
      logic [LSU_REG_W-1:0]  dest;
   } lsu_entry_t;

endpackage

// File: rtl/lsu_fifo.sv
// Circular FIFO of pending memory ops with an extra wrap bit on each pointer
// so full and empty are distinguishable; the head entry is readable combinationally.
module lsu_fifo
   import lsu_pkg::*;
#(
   parameter int unsigned DEPTH   = 4,
   parameter type         entry_t = lsu_entry_t
) (
   input  logic   clk,
   input  logic   async_rst,
   input  logic   push_i,
   input  entry_t push_data_i,
   input  logic   pop_i,
   output entry_t head_o,
   output logic   full_o,
   output logic   empty_o
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [AW:0] wr_ptr_q, wr_ptr_d;
   logic [AW:0] rd_ptr_q, rd_ptr_d;
   entry_t      mem_q [DEPTH];

   assign wr_ptr_d = push_i ? wr_ptr_q + 1'b1 : wr_ptr_q;
   assign rd_ptr_d = pop_i  ? rd_ptr_q + 1'b1 : rd_ptr_q;

   always_ff @(posedge clk or posedge async_rst) begin
      if (async_rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage holds no meaningful state after reset, so it is left unreset.
   always_ff @(posedge clk) begin
      if (push_i) begin
         mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
      end
   end

   assign head_o  = mem_q[rd_ptr_q[AW-1:0]];
   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

endmodule

// File: rtl/load_store_queue.sv
// In-order load/store queue: buffers issue-stage memory ops and runs them one at a
// time through a memory handshake. Optional macro LSU_ENQUEUE_BYPASS_EN skips the FIFO when idle.
module load_store_queue
   import lsu_pkg::*;
#(
   parameter int unsigned DATABITWIDTH    = 16,
   parameter int unsigned REGADDRBITWIDTH = 4,
   parameter int unsigned QUEUEDEPTH      = 4
) (
   input  logic                       clk,
   input  logic                       async_rst,
   input  logic                       clk_en,
   output logic                       LoadStore_REQ,
   input  logic                       LoadStore_ACK,
   input  logic [3:0]                 MinorOpcode,
   input  logic [DATABITWIDTH-1:0]    Data_A,
   input  logic [DATABITWIDTH-1:0]    Data_B,
   input  logic [REGADDRBITWIDTH-1:0] WritebackRegAddr,
   output logic                       Mem_REQ,
   input  logic                       Mem_ACK,
   output logic                       Mem_WriteEn,
   output logic [DATABITWIDTH-1:0]    Mem_Addr,
   output logic [DATABITWIDTH-1:0]    Mem_WriteData,
   input  logic                       Mem_RespValid,
   input  logic [DATABITWIDTH-1:0]    Mem_RespData,
   output logic                       LoadWB_Valid,
   input  logic                       LoadWB_Ack,
   output logic [DATABITWIDTH-1:0]    LoadWB_Data,
   output logic [REGADDRBITWIDTH-1:0] LoadWB_Addr,
   output logic                       QueueEmpty
);

   typedef struct packed {
      logic                       store;
      logic [DATABITWIDTH-1:0]    addr;
      logic [DATABITWIDTH-1:0]    wdata;
      logic [REGADDRBITWIDTH-1:0] dest;
   } entry_t;

   lsu_state_e              state_q, state_d;
   entry_t                  wk_q, wk_d;
   logic [DATABITWIDTH-1:0] rdata_q, rdata_d;

   entry_t in_entry;
   entry_t fifo_head;
   logic   fifo_full;
   logic   fifo_empty;
   logic   enq;
   logic   bypass;
   logic   push;
   logic   pop;
   logic   unused_opc;

   assign in_entry.store = MinorOpcode[LSU_STORE_BIT];
   assign in_entry.addr  = Data_A;
   assign in_entry.wdata = Data_B;
   assign in_entry.dest  = WritebackRegAddr;
   assign unused_opc     = ^MinorOpcode[2:0];

   assign LoadStore_REQ = ~fifo_full;
   assign enq           = LoadStore_REQ & LoadStore_ACK & clk_en;

`ifdef LSU_ENQUEUE_BYPASS_EN
   assign bypass = enq & fifo_empty & (state_q == ST_IDLE);
`else
   assign bypass = 1'b0;
`endif

   assign push = enq & ~bypass;
   assign pop  = clk_en & (state_q == ST_IDLE) & ~fifo_empty;

   lsu_fifo #(
      .DEPTH   (QUEUEDEPTH),
      .entry_t (entry_t)
   ) u_fifo (
      .clk         (clk),
      .async_rst   (async_rst),
      .push_i      (push),
      .push_data_i (in_entry),
      .pop_i       (pop),
      .head_o      (fifo_head),
      .full_o      (fifo_full),
      .empty_o     (fifo_empty)
   );

   always_ff @(posedge clk or posedge async_rst) begin
      if (async_rst) begin
         state_q <= ST_IDLE;
         wk_q    <= '0;
         rdata_q <= '0;
      end else if (clk_en) begin
         state_q <= state_d;
         wk_q    <= wk_d;
         rdata_q <= rdata_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:      if (!fifo_empty || bypass) state_d = ST_REQUEST;
         ST_REQUEST:   if (Mem_ACK) state_d = wk_q.store ? ST_IDLE : ST_WAIT_RESP;
         ST_WAIT_RESP: if (Mem_RespValid) state_d = ST_WRITEBACK;
         ST_WRITEBACK: if (LoadWB_Ack) state_d = ST_IDLE;
         default:      state_d = ST_IDLE;
      endcase
   end

   // Working registers take the FIFO head on a pop, or the incoming op on a bypass.
   always_comb begin
      wk_d    = wk_q;
      rdata_d = rdata_q;
      if (pop) begin
         wk_d = fifo_head;
      end else if (bypass) begin
         wk_d = in_entry;
      end
      if (state_q == ST_WAIT_RESP && Mem_RespValid) begin
         rdata_d = Mem_RespData;
      end
   end

   always_comb begin
      Mem_REQ      = 1'b0;
      Mem_WriteEn  = 1'b0;
      LoadWB_Valid = 1'b0;
      unique case (state_q)
         ST_REQUEST: begin
            Mem_REQ     = 1'b1;
            Mem_WriteEn = wk_q.store;
         end
         ST_WRITEBACK: LoadWB_Valid = 1'b1;
         default: ;
      endcase
   end

   assign Mem_Addr      = wk_q.addr;
   assign Mem_WriteData = wk_q.wdata;
   assign LoadWB_Data   = rdata_q;
   assign LoadWB_Addr   = wk_q.dest;
   assign QueueEmpty    = fifo_empty & (state_q == ST_IDLE);

endmodule

// File: tb/tb_load_store_queue.sv
// Directed self-checking bench for load_store_queue: reset, load, store, full,
// stall, enqueue latency, and reset during an outstanding load.
module tb_load_store_queue;

   localparam int DW = 16;
   localparam int RW = 4;
`ifdef LSU_ENQUEUE_BYPASS_EN
   localparam int EXP_LAT = 1;
`else
   localparam int EXP_LAT = 2;
`endif

   logic          clk = 1'b0;
   logic          async_rst;
   logic          clk_en;
   logic          LoadStore_REQ;
   logic          LoadStore_ACK;
   logic [3:0]    MinorOpcode;
   logic [DW-1:0] Data_A;
   logic [DW-1:0] Data_B;
   logic [RW-1:0] WritebackRegAddr;
   logic          Mem_REQ;
   logic          Mem_ACK;
   logic          Mem_WriteEn;
   logic [DW-1:0] Mem_Addr;
   logic [DW-1:0] Mem_WriteData;
   logic          Mem_RespValid;
   logic [DW-1:0] Mem_RespData;
   logic          LoadWB_Valid;
   logic          LoadWB_Ack;
   logic [DW-1:0] LoadWB_Data;
   logic [RW-1:0] LoadWB_Addr;
   logic          QueueEmpty;

   int n_pass  = 0;
   int n_total = 0;

   load_store_queue #(
      .DATABITWIDTH    (DW),
      .REGADDRBITWIDTH (RW),
      .QUEUEDEPTH      (4)
   ) dut (
      .clk              (clk),
      .async_rst        (async_rst),
      .clk_en           (clk_en),
      .LoadStore_REQ    (LoadStore_REQ),
      .LoadStore_ACK    (LoadStore_ACK),
      .MinorOpcode      (MinorOpcode),
      .Data_A           (Data_A),
      .Data_B           (Data_B),
      .WritebackRegAddr (WritebackRegAddr),
      .Mem_REQ          (Mem_REQ),
      .Mem_ACK          (Mem_ACK),
      .Mem_WriteEn      (Mem_WriteEn),
      .Mem_Addr         (Mem_Addr),
      .Mem_WriteData    (Mem_WriteData),
      .Mem_RespValid    (Mem_RespValid),
      .Mem_RespData     (Mem_RespData),
      .LoadWB_Valid     (LoadWB_Valid),
      .LoadWB_Ack       (LoadWB_Ack),
      .LoadWB_Data      (LoadWB_Data),
      .LoadWB_Addr      (LoadWB_Addr),
      .QueueEmpty       (QueueEmpty)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic enq(input logic st, input logic [DW-1:0] a, input logic [DW-1:0] d,
                      input logic [RW-1:0] r);
      MinorOpcode      = {st, 3'b000};
      Data_A           = a;
      Data_B           = d;
      WritebackRegAddr = r;
      for (int i = 0; i < 20 && !LoadStore_REQ; i++) tick();
      check_eq("enq_ready", LoadStore_REQ, 1);
      LoadStore_ACK = 1'b1;
      tick();
      LoadStore_ACK = 1'b0;
      $display("enq store=%0d addr=%h data=%h dest=%0d", st, a, d, r);
   endtask

   task automatic wait_memreq();
      for (int i = 0; i < 20 && !Mem_REQ; i++) tick();
      check_eq("memreq_seen", Mem_REQ, 1);
   endtask

   initial begin
      int lat;
      async_rst        = 1'b1;
      clk_en           = 1'b1;
      LoadStore_ACK    = 1'b0;
      MinorOpcode      = '0;
      Data_A           = '0;
      Data_B           = '0;
      WritebackRegAddr = '0;
      Mem_ACK          = 1'b0;
      Mem_RespValid    = 1'b0;
      Mem_RespData     = '0;
      LoadWB_Ack       = 1'b0;
      #1;
      check_eq("rst_lsreq", LoadStore_REQ, 1);
      check_eq("rst_memreq", Mem_REQ, 0);
      check_eq("rst_wben", Mem_WriteEn, 0);
      check_eq("rst_addr", Mem_Addr, 0);
      check_eq("rst_wbvalid", LoadWB_Valid, 0);
      check_eq("rst_qempty", QueueEmpty, 1);
      tick();
      tick();
      async_rst = 1'b0;
      tick();

      // Load: memory accepts immediately, data returns two cycles later
      Mem_ACK = 1'b1;
      enq(1'b0, 16'h0010, 16'h0000, 4'd5);
      wait_memreq();
      check_eq("ld_wen", Mem_WriteEn, 0);
      check_eq("ld_addr", Mem_Addr, 16'h0010);
      tick();
      Mem_ACK = 1'b0;
      check_eq("ld_memreq_off", Mem_REQ, 0);
      tick();
      check_eq("ld_wb_pending", LoadWB_Valid, 0);
      Mem_RespValid = 1'b1;
      Mem_RespData  = 16'h1234;
      tick();
      Mem_RespValid = 1'b0;
      check_eq("ld_wb_valid", LoadWB_Valid, 1);
      check_eq("ld_wb_data", LoadWB_Data, 16'h1234);
      check_eq("ld_wb_addr", LoadWB_Addr, 5);
      LoadWB_Ack = 1'b1;
      tick();
      LoadWB_Ack = 1'b0;
      check_eq("ld_wb_done", LoadWB_Valid, 0);
      check_eq("ld_qempty", QueueEmpty, 1);
      $display("txn load addr=0010 data=%h dest=%0d", LoadWB_Data, LoadWB_Addr);

      // Store
      enq(1'b1, 16'h0020, 16'hA5A5, 4'd0);
      wait_memreq();
      check_eq("st_wen", Mem_WriteEn, 1);
      check_eq("st_addr", Mem_Addr, 16'h0020);
      check_eq("st_wdata", Mem_WriteData, 16'hA5A5);
      Mem_ACK = 1'b1;
      tick();
      Mem_ACK = 1'b0;
      check_eq("st_memreq_off", Mem_REQ, 0);
      check_eq("st_no_wb", LoadWB_Valid, 0);
      check_eq("st_qempty", QueueEmpty, 1);
      $display("txn store addr=0020 data=A5A5");

      // Full: head in working regs plus four entries in the FIFO
      for (int i = 0; i < 5; i++) enq(1'b1, 16'h0100 + 16'(i), 16'h5000 + 16'(i), 4'd0);
      check_eq("full_lsreq", LoadStore_REQ, 0);
      Mem_ACK = 1'b1;
      for (int i = 0; i < 5; i++) begin
         wait_memreq();
         check_eq("drain_addr", Mem_Addr, 16'h0100 + 16'(i));
         check_eq("drain_wdata", Mem_WriteData, 16'h5000 + 16'(i));
         tick();
         $display("txn drain store addr=%h", 16'h0100 + 16'(i));
      end
      Mem_ACK = 1'b0;
      check_eq("drain_qempty", QueueEmpty, 1);

      // Stall in REQUEST with Mem_ACK high
      enq(1'b1, 16'h0040, 16'h7777, 4'd0);
      wait_memreq();
      clk_en  = 1'b0;
      Mem_ACK = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check_eq("stall_memreq", Mem_REQ, 1);
         check_eq("stall_addr", Mem_Addr, 16'h0040);
      end
      clk_en = 1'b1;
      tick();
      Mem_ACK = 1'b0;
      check_eq("stall_release", Mem_REQ, 0);
      check_eq("stall_qempty", QueueEmpty, 1);
      $display("txn stall store addr=0040");

      // Enqueue-to-request latency
      MinorOpcode   = 4'b1000;
      Data_A        = 16'h0050;
      Data_B        = 16'h0505;
      LoadStore_ACK = 1'b1;
      tick();
      LoadStore_ACK = 1'b0;
      lat = 1;
      while (!Mem_REQ && lat < 10) begin
         tick();
         lat++;
      end
      check_eq("latency", lat, EXP_LAT);
      Mem_ACK = 1'b1;
      tick();
      Mem_ACK = 1'b0;
      $display("txn latency store addr=0050 lat=%0d", lat);

      // Reset while a load waits for its response, with another op queued
      Mem_ACK = 1'b1;
      enq(1'b0, 16'h0030, 16'h0000, 4'd7);
      wait_memreq();
      tick();
      Mem_ACK = 1'b0;
      enq(1'b1, 16'h0060, 16'h6666, 4'd0);
      check_eq("pre_rst_qempty", QueueEmpty, 0);
      async_rst = 1'b1;
      #1;
      check_eq("arst_memreq", Mem_REQ, 0);
      check_eq("arst_addr", Mem_Addr, 0);
      check_eq("arst_wdata", Mem_WriteData, 0);
      check_eq("arst_wbaddr", LoadWB_Addr, 0);
      check_eq("arst_lsreq", LoadStore_REQ, 1);
      check_eq("arst_qempty", QueueEmpty, 1);
      tick();
      async_rst     = 1'b0;
      Mem_RespValid = 1'b1;
      Mem_RespData  = 16'hBEEF;
      tick();
      Mem_RespValid = 1'b0;
      check_eq("late_resp_wbvalid", LoadWB_Valid, 0);
      check_eq("late_resp_wbdata", LoadWB_Data, 0);
      tick();
      check_eq("late_resp_wbvalid2", LoadWB_Valid, 0);
      check_eq("late_resp_memreq", Mem_REQ, 0);
      $display("txn reset mid-load discarded");

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
